// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte requesters, the arbiter and the UART serializer.
// The arbiter takes the slave modport; requesters and serializer drive the master side.
interface uart_tx_arb_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_en;
  logic [NREQ-1:0]   req_ready;
  logic              tx_rdy;
  logic [7:0]        tx_data;
  logic              tx_ack;
  logic              busy;
  logic [2:0]        grant_id;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output req_valid, req_data, req_en, tx_ack,
    input  req_ready, tx_rdy, tx_data, busy, grant_id, frame_cnt
  );

  modport slave (
    input  req_valid, req_data, req_en, tx_ack,
    output req_ready, tx_rdy, tx_data, busy, grant_id, frame_cnt
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one byte at a time from NREQ requesters to a UART serializer.
// A byte is released only on a fresh rising edge of the serializer's tx_ack.
module uart_tx_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b01,
    WAIT_ACK = 2'b10
  } state_e;

  state_e           state, state_nxt;
  logic [2:0]       rr_ptr, rr_nxt;
  logic [2:0]       grant_q, grant_nxt;
  logic             tx_rdy_q, tx_rdy_nxt;
  logic [7:0]       tx_data_q, tx_data_nxt;
  logic             busy_q, busy_nxt;
  logic [NREQ-1:0]  ready_q;
  logic [7:0]       ready_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             ack_d, ack_evt;
  logic [7:0]       elig;
  logic [7:0]       data_arr [8];
  logic             pick_vld;
  logic [2:0]       pick_idx;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) s -= NREQ;
    return 3'(s);
  endfunction

  // Level-high tx_ack from a previous byte must never release the current one.
  assign ack_evt = bus.tx_ack & ~ack_d;

  always_comb begin
    elig = '0;
    elig[NREQ-1:0] = bus.req_valid & bus.req_en;
    data_arr = '{default: 8'h00};
    for (int i = 0; i < NREQ; i++) data_arr[i] = bus.req_data[8*i +: 8];
  end

  // Scan from the farthest offset down so the nearest eligible index at or after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (elig[wrap_idx(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    grant_nxt   = grant_q;
    tx_rdy_nxt  = tx_rdy_q;
    tx_data_nxt = tx_data_q;
    busy_nxt    = busy_q;
    cnt_nxt     = cnt_q;
    ready_nxt   = '0;
    case (state)
      IDLE: begin
        tx_rdy_nxt = 1'b0;
        busy_nxt   = 1'b0;
        // No grant during the req_ready cycle: the accepted requester still shows req_valid.
        if (pick_vld && ready_q == '0) begin
          grant_nxt   = pick_idx;
          tx_data_nxt = data_arr[pick_idx];
          tx_rdy_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_evt) begin
          ready_nxt[grant_q] = 1'b1;
          rr_nxt             = wrap_idx(grant_q, 1);
          cnt_nxt            = cnt_q + 1'b1;
          tx_rdy_nxt         = 1'b0;
          busy_nxt           = 1'b0;
          state_nxt          = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        tx_rdy_nxt = 1'b0;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_q   <= '0;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      ready_q   <= '0;
      cnt_q     <= '0;
      ack_d     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_q   <= grant_nxt;
      tx_rdy_q  <= tx_rdy_nxt;
      tx_data_q <= tx_data_nxt;
      busy_q    <= busy_nxt;
      ready_q   <= ready_nxt[NREQ-1:0];
      cnt_q     <= cnt_nxt;
      ack_d     <= bus.tx_ack;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_rdy    = tx_rdy_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: the bench plays requesters and serializer and predicts
// grants from a plain round-robin model; a 4-bit-counter twin runs in lockstep for wrap.
module tb_uart_tx_arb;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_tx_arb_if #(.NREQ(NREQ), .CNT_W(16)) bus  ();
  uart_tx_arb_if #(.NREQ(NREQ), .CNT_W(4))  bus4 ();

  uart_tx_arb #(.NREQ(NREQ), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  uart_tx_arb #(.NREQ(NREQ), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.req_valid = bus.req_valid;
  assign bus4.req_data  = bus.req_data;
  assign bus4.req_en    = bus.req_en;
  assign bus4.tx_ack    = bus.tx_ack;

  always #5 clk = ~clk;

  bit        m_valid [NREQ];
  bit        m_en    [NREQ];
  logic [7:0] m_data [NREQ];
  int        m_rr;
  int        m_cnt;
  int        vectors;
  int        miscompares;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = m_valid[i];
      bus.req_en[i]           = m_en[i];
      bus.req_data[8*i +: 8]  = m_data[i];
    end
  endtask

  // Round-robin reference: first requester at or after m_rr (mod NREQ) that is valid and enabled.
  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (m_valid[(m_rr + k) % NREQ] && m_en[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.tx_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b0;
      m_en[i]    = 1'b1;
      m_data[i]  = 8'h00;
    end
    drive();
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    m_rr  = 0;
    m_cnt = 0;
  endtask

  // One complete frame: offer, hold, ack edge, req_ready pulse. Called at a negedge while idle.
  task automatic run_frame(input int hold, input bit refill, input bit mutate,
                           input bit keep_ack, output int g);
    int         exp_g;
    logic [7:0] exp_d;
    int         t;
    int         r;
    if (model_pick() < 0) begin
      r = $urandom_range(NREQ - 1);
      if (!m_valid[r]) m_data[r] = 8'($urandom);
      m_valid[r] = 1'b1;
      m_en[r]    = 1'b1;
      drive();
    end
    exp_g = model_pick();
    exp_d = m_data[exp_g];
    g = -1;
    t = 0;
    while (bus.tx_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t != 1) begin
      $display("FAIL offer_latency: tx_rdy seen after %0d cycles (tx_rdy=%b), required 1", t, bus.tx_rdy);
      miscompares++;
      if (bus.tx_rdy !== 1'b1) return;
    end
    g = int'(bus.grant_id);
    vectors++;
    if (bus.grant_id !== 3'(exp_g) || bus.tx_data !== exp_d || bus.busy !== 1'b1 || bus.req_ready !== 4'b0) begin
      $display("FAIL offer: grant=%0d data=%h busy=%b ready=%b, required grant=%0d data=%h busy=1 ready=0000",
               bus.grant_id, bus.tx_data, bus.busy, bus.req_ready, exp_g, exp_d);
      miscompares++;
    end
    if (mutate) begin
      for (int i = 0; i < NREQ; i++) begin
        m_en[i] = 1'($urandom);
        if (i != exp_g && !m_valid[i] && $urandom_range(1) == 1) begin
          m_valid[i] = 1'b1;
          m_data[i]  = 8'($urandom);
        end
      end
      drive();
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.tx_rdy !== 1'b1 || bus.tx_data !== exp_d || bus.req_ready !== 4'b0) begin
        $display("FAIL hold[%0d]: tx_rdy=%b data=%h ready=%b, required tx_rdy=1 data=%h ready=0000",
                 i, bus.tx_rdy, bus.tx_data, bus.req_ready, exp_d);
        miscompares++;
      end
    end
    if (bus.tx_ack) begin
      bus.tx_ack = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.tx_rdy !== 1'b1 || bus.req_ready !== 4'b0) begin
        $display("FAIL stale_ack: tx_rdy=%b ready=%b, required tx_rdy=1 ready=0000", bus.tx_rdy, bus.req_ready);
        miscompares++;
      end
    end
    bus.tx_ack = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'(1 << exp_g) || bus.tx_rdy !== 1'b0 || bus.busy !== 1'b0 ||
        bus.frame_cnt !== 16'(m_cnt + 1) || bus4.frame_cnt !== 4'(m_cnt + 1)) begin
      $display("FAIL release: ready=%b tx_rdy=%b busy=%b cnt=%0d cnt4=%0d, required ready=%b tx_rdy=0 busy=0 cnt=%0d cnt4=%0d",
               bus.req_ready, bus.tx_rdy, bus.busy, bus.frame_cnt, bus4.frame_cnt,
               4'(1 << exp_g), 16'(m_cnt + 1), 4'(m_cnt + 1));
      miscompares++;
    end
    m_cnt++;
    m_rr = (exp_g + 1) % NREQ;
    if (refill) m_data[exp_g] = 8'($urandom);
    else m_valid[exp_g] = 1'b0;
    drive();
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 4'b0 || bus.frame_cnt !== 16'(m_cnt)) begin
      $display("FAIL pulse_width: ready=%b cnt=%0d, required ready=0000 cnt=%0d",
               bus.req_ready, bus.frame_cnt, m_cnt);
      miscompares++;
    end
    if (!keep_ack) bus.tx_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.tx_rdy !== 1'b0 || bus.tx_data !== 8'h00 || bus.req_ready !== 4'b0 ||
        bus.busy !== 1'b0 || bus.grant_id !== 3'd0 || bus.frame_cnt !== 16'd0 || bus4.frame_cnt !== 4'd0) begin
      $display("FAIL reset_state: tx_rdy=%b data=%h ready=%b busy=%b grant=%0d cnt=%0d, required all zero",
               bus.tx_rdy, bus.tx_data, bus.req_ready, bus.busy, bus.grant_id, bus.frame_cnt);
      miscompares++;
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b1;
      m_en[i]    = 1'b0;
      m_data[i]  = 8'($urandom);
    end
    drive();
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (bus.tx_rdy !== 1'b0 || bus.busy !== 1'b0) begin
        $display("FAIL idle_masked: tx_rdy=%b busy=%b, required 0 0", bus.tx_rdy, bus.busy);
        miscompares++;
      end
    end
    bus.tx_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 4'b0 || bus.frame_cnt !== 16'(m_cnt)) begin
        $display("FAIL idle_ack: ready=%b cnt=%0d, required ready=0000 cnt=%0d", bus.req_ready, bus.frame_cnt, m_cnt);
        miscompares++;
      end
    end
    bus.tx_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b0;
      m_en[i]    = 1'b1;
    end
    drive();
  endtask

  task automatic test_single();
    int g;
    do_reset();
    m_valid[0] = 1'b1;
    m_data[0]  = 8'hA5;
    drive();
    run_frame(5, 1'b0, 1'b0, 1'b0, g);
    vectors++;
    if (g != 0 || bus.frame_cnt !== 16'd1) begin
      $display("FAIL single: grant=%0d cnt=%0d, required grant=0 cnt=1", g, bus.frame_cnt);
      miscompares++;
    end
  endtask

  task automatic test_fairness();
    int g;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b1;
      m_data[i]  = 8'($urandom);
    end
    drive();
    for (int n = 0; n < 6; n++) begin
      run_frame($urandom_range(1, 3), 1'b1, 1'b0, 1'b0, g);
      vectors++;
      if (g != order[n]) begin
        $display("FAIL fairness[%0d]: grant=%0d, required %0d", n, g, order[n]);
        miscompares++;
      end
    end
  endtask

  task automatic test_mask_wrap();
    int g;
    int order [4] = '{3, 1, 3, 1};
    do_reset();
    m_valid[2] = 1'b1;
    m_data[2]  = 8'h3C;
    drive();
    run_frame(1, 1'b0, 1'b0, 1'b0, g);
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 1'b1;
      m_data[i]  = 8'($urandom);
      m_en[i]    = (i == 1 || i == 3);
    end
    drive();
    for (int n = 0; n < 4; n++) begin
      run_frame($urandom_range(0, 2), 1'b1, 1'b0, 1'b0, g);
      vectors++;
      if (g != order[n]) begin
        $display("FAIL mask_wrap[%0d]: grant=%0d, required %0d", n, g, order[n]);
        miscompares++;
      end
    end
  endtask

  task automatic test_stale_ack();
    int g0;
    int g1;
    do_reset();
    m_valid[0] = 1'b1;
    m_valid[1] = 1'b1;
    m_data[0]  = 8'h11;
    m_data[1]  = 8'h22;
    drive();
    run_frame(2, 1'b0, 1'b0, 1'b1, g0);
    run_frame(4, 1'b0, 1'b0, 1'b0, g1);
    vectors++;
    if (g0 != 0 || g1 != 1) begin
      $display("FAIL stale_order: grants=%0d,%0d, required 0,1", g0, g1);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    int g;
    int t;
    do_reset();
    m_valid[1] = 1'b1;
    m_valid[3] = 1'b1;
    m_data[1]  = 8'h5A;
    m_data[3]  = 8'hC3;
    drive();
    run_frame(1, 1'b1, 1'b0, 1'b0, g);
    t = 0;
    while (bus.tx_rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (bus.tx_rdy !== 1'b1 || bus.grant_id !== 3'd3) begin
      $display("FAIL mid_offer: tx_rdy=%b grant=%0d, required 1 3", bus.tx_rdy, bus.grant_id);
      miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.tx_rdy !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0 || bus.frame_cnt !== 16'd0) begin
      $display("FAIL mid_reset: tx_rdy=%b busy=%b ready=%b cnt=%0d, required 0 0 0000 0",
               bus.tx_rdy, bus.busy, bus.req_ready, bus.frame_cnt);
      miscompares++;
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.req_ready !== 4'b0 || bus.tx_rdy !== 1'b0) begin
        $display("FAIL mid_hold: ready=%b tx_rdy=%b, required 0000 0", bus.req_ready, bus.tx_rdy);
        miscompares++;
      end
    end
    rst   = 1'b1;
    m_rr  = 0;
    m_cnt = 0;
    run_frame(1, 1'b0, 1'b0, 1'b0, g);
    vectors++;
    if (g != 1) begin
      $display("FAIL first_after_reset: grant=%0d, required 1", g);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!m_valid[i] && $urandom_range(1) == 1) begin
          m_valid[i] = 1'b1;
          m_data[i]  = 8'($urandom);
        end
        m_en[i] = ($urandom_range(3) != 0);
      end
      drive();
      run_frame($urandom_range(0, 4), 1'($urandom), 1'b1, 1'b0, g);
    end
  endtask

  task automatic test_counter_wrap();
    int g;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!m_valid[i]) m_data[i] = 8'($urandom);
        m_valid[i] = 1'b1;
      end
      drive();
      run_frame($urandom_range(0, 2), 1'b1, 1'b0, 1'b0, g);
    end
    vectors++;
    if (bus4.frame_cnt !== 4'd0 || bus.frame_cnt !== 16'd16) begin
      $display("FAIL counter_wrap: cnt4=%0d cnt16=%0d, required 0 16", bus4.frame_cnt, bus.frame_cnt);
      miscompares++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_rr        = 0;
    m_cnt       = 0;
    bus.tx_ack    = 1'b0;
    bus.req_valid = '0;
    bus.req_en    = '0;
    bus.req_data  = '0;
    test_reset();
    test_idle();
    test_single();
    test_fairness();
    test_mask_wrap();
    test_stale_ack();
    test_reset_mid();
    test_random();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters; legal range is 2..8.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the sent-frame counter.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-low reset: 0 = reset, 1 = run.
REQ-005 req_valid  in  NREQ  SHALL be the per-requester "byte pending" flag; it is held high with data stable until the matching req_ready pulse.
REQ-006 req_data  in  8*NREQ  SHALL carry the requester bytes; requester i uses bits [8i+7:8i].
REQ-007 req_en  in  NREQ  SHALL be the per-requester arbitration enable; 0 excludes that requester from new grants.
REQ-008 req_ready  out  NREQ  SHALL be a one-cycle, one-hot pulse that accepts the byte of the indicated requester.
REQ-009 tx_rdy  out  1  SHALL be the "byte offered" strobe to the serializer.
REQ-010 tx_data  out  8  SHALL be the byte offered to the serializer.
REQ-011 tx_ack  in  1  SHALL be the serializer's accept flag, registered, high for one full baud period per accepted byte.
REQ-012 busy  out  1  SHALL be high whenever a byte is offered and not yet acknowledged.
REQ-013 grant_id  out  3  SHALL be the index of the requester currently or last granted.
REQ-014 frame_cnt  out  CNT_W  SHALL count bytes acknowledged by the serializer.

Function
REQ-015 The block SHALL implement two states: IDLE and WAIT_ACK.
REQ-016 In IDLE, a requester is eligible when req_valid[i] and req_en[i] are both 1.
REQ-017 In IDLE, if any requester is eligible, the block SHALL pick one round-robin and latch req_data into tx_data the same cycle.
REQ-018 The search SHALL start at index rr_ptr and wrap from NREQ-1 to 0.
REQ-019 On a grant, the block SHALL set grant_id, set tx_rdy = 1 and busy = 1, and go to WAIT_ACK, all registered, so the offer is visible one cycle after the decision.
REQ-020 If no requester is eligible in IDLE, the block SHALL stay in IDLE with tx_rdy = 0.
REQ-021 The block SHALL register tx_ack into ack_d every cycle.
REQ-022 An acknowledge event SHALL be defined as tx_ack = 1 and ack_d = 0; level-high tx_ack alone is not an acknowledge.
REQ-023 In WAIT_ACK, tx_rdy and tx_data SHALL be held constant until an acknowledge event.
REQ-024 On an acknowledge event in WAIT_ACK, the next cycle SHALL have: tx_rdy = 0, busy = 0, req_ready[grant_id] = 1 for exactly one cycle, rr_ptr = (grant_id+1) mod NREQ, frame_cnt incremented, state IDLE.
REQ-025 frame_cnt SHALL wrap from all-ones to 0 without saturation or flag.
REQ-026 An acknowledge event while in IDLE SHALL be ignored: no counter change, no req_ready pulse.
REQ-027 A tx_ack still high from the previous byte when a new grant is made SHALL NOT acknowledge the new byte; a fresh 0->1 edge is required.
REQ-028 Changes to req_en or req_valid during WAIT_ACK SHALL NOT affect the transfer in flight; its req_ready pulse is still issued.
REQ-029 Minimum spacing between two grants SHALL be one IDLE cycle after the req_ready pulse; back-to-back frames rely on the serializer accepting at stop bit.
REQ-030 Unreachable state encodings SHALL return to IDLE with tx_rdy = 0.

Reset
REQ-031 While rst = 0, the block SHALL hold: state = IDLE, tx_rdy = 0, tx_data = 0x00, req_ready = 0, busy = 0, grant_id = 0, rr_ptr = 0, ack_d = 0, frame_cnt = 0.
REQ-032 Reset asserted mid-WAIT_ACK SHALL abandon the offer with no req_ready pulse.
REQ-033 After reset release, the first grant SHALL be the lowest eligible index at or above 0.

Verification
REQ-034 Single requester: NREQ=4, req_valid=0001, data0=0xA5, req_en=1111, ack edge 5 cycles after tx_rdy -> tx_data=0xA5, tx_rdy high until the ack edge, then req_ready=0001 for one cycle and frame_cnt=1.
REQ-035 Fairness: all four valid continuously, ack edge per offer -> grant order 0,1,2,3,0,1; no requester granted twice before the others.
REQ-036 Masking and wrap: valid=1111, req_en=1010, rr_ptr=3 -> grants 3,1,3,1; requesters 0 and 2 never get req_ready.
REQ-037 Stale ack: tx_ack held high across req_ready and the next grant -> second byte is not acknowledged until tx_ack goes 0 then 1.
REQ-038 Reset mid-transfer: rst=0 in WAIT_ACK -> tx_rdy=0, busy=0 immediately; no req_ready; frame_cnt=0. Counter wrap: CNT_W=4, 16 acks -> frame_cnt=0.
